// File: rtl/sdc_pkg.sv
// Shared definitions for the SD controller receive datapath.
// Contents:
//   - byte-lane index width
//   - byte-keep constants
//   - packer state enumeration
//   - helper that maps the index of a word's final byte to its keep mask
package sdc_pkg;

  localparam int unsigned IDX_W = 2;

  localparam logic [3:0] KEEP_1B = 4'b0001;
  localparam logic [3:0] KEEP_2B = 4'b0011;
  localparam logic [3:0] KEEP_3B = 4'b0111;
  localparam logic [3:0] KEEP_4B = 4'b1111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } pk_state_e;

  // Keep mask for a word whose final byte landed in lane idx.
  function automatic logic [3:0] keep_upto(input logic [IDX_W-1:0] idx);
    logic [3:0] k;
    case (idx)
      2'd0:    k = KEEP_1B;
      2'd1:    k = KEEP_2B;
      2'd2:    k = KEEP_3B;
      default: k = KEEP_4B;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sdc_word_fifo.sv
// Synchronous FIFO for packed receive words.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i, data_i  write strobe and entry; ignored when full unless pop_i
//   full_o          FIFO holds DEPTH entries
//   pop_i           remove head; ignored when empty
//   empty_o         no entries
//   data_o          head entry, driven straight from storage registers
module sdc_word_fifo #(
  parameter int unsigned W     = 36,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  input  logic         pop_i,
  output logic         empty_o,
  output logic [W-1:0] data_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          wr_en, rd_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rd_en   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
  assign wr_en   = push_i && (!full_o || pop_i);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (rd_en) rd_q <= rd_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sdc_rx_byte_packer.sv
// Packs the SD receiver byte stream into 32-bit little-endian words with
// byte-keep, counts blocks and buffers words toward the DMA.
// Ports:
//   clk, rst                  sd_clk, synchronous active-high reset
//   rx_data_in/valid/last     byte stream from the receiver (no backpressure)
//   block_cnt                 blocks to receive, 0 = unlimited
//   rx_data_out/keep/valid    FIFO head word, keep mask, valid
//   rx_ready_out              consumer accept
//   rx_finish                 all blocks packed and drained (sticky)
//   overflow                  a word was dropped on a full FIFO (sticky)
module sdc_rx_byte_packer
  import sdc_pkg::*;
#(
  parameter int unsigned BLKCNT_W   = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data_in,
  input  logic                rx_valid_in,
  input  logic                rx_last_in,
  input  logic [BLKCNT_W-1:0] block_cnt,
  output logic [31:0]         rx_data_out,
  output logic [3:0]          rx_keep_out,
  output logic                rx_valid_out,
  input  logic                rx_ready_out,
  output logic                rx_finish,
  output logic                overflow
);

  pk_state_e         state_q;
  logic [31:0]       asm_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BLKCNT_W-1:0] blk_q;
  logic              finish_q, ovf_q;

  logic        accept, complete, final_blk, pop, full, empty;
  logic [31:0] word_d;
  logic [35:0] head;

  assign accept    = rx_valid_in && (state_q == RUN);
  assign complete  = accept && ((idx_q == IDX_W'(3)) || rx_last_in);
  assign final_blk = rx_last_in && (block_cnt != '0) && (blk_q == block_cnt - 1'b1);
  assign pop       = rx_valid_out && rx_ready_out;

  // Unused lanes stay zero because asm_q is cleared after every flush.
  always_comb begin
    word_d = asm_q;
    word_d = asm_q | ({24'b0, rx_data_in} << {idx_q, 3'b000});
  end

  sdc_word_fifo #(
    .W     (36),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (complete),
    .data_i  ({word_d, keep_upto(idx_q)}),
    .full_o  (full),
    .pop_i   (pop),
    .empty_o (empty),
    .data_o  (head)
  );

  assign rx_data_out  = head[35:4];
  assign rx_keep_out  = head[3:0];
  assign rx_valid_out = !empty;
  assign rx_finish    = finish_q;
  assign overflow     = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      asm_q    <= '0;
      idx_q    <= '0;
      blk_q    <= '0;
      finish_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept) begin
            if (complete) begin
              asm_q <= '0;
              idx_q <= '0;
              if (full && !pop) ovf_q <= 1'b1;
            end else begin
              asm_q <= word_d;
              idx_q <= idx_q + 1'b1;
            end
            if (rx_last_in) begin
              blk_q <= blk_q + 1'b1;
              if (final_blk) state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (empty) begin
            state_q  <= DONE;
            finish_q <= 1'b1;
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule
